rtc_bus_ctrl: RTL and testbench

//  Transaction sequencer for the multiplexed 8-bit address/data bus of the parallel RTC.

---
 rtl/rtc_bus_ctrl_pkg.sv | 64 ++++++
 rtl/rtc_bus_ctrl_phase_timer.sv | 44 ++++
 rtl/rtc_bus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the parallel RTC bus sequencer.
//  - state_t      : sequencer states, in bus-cycle order
//  - bus_ctl_t    : registered bus control bundle (strobes, enables, status)
//  - CtlIdle      : control bundle value while idle / in reset
//  - TPhaseDefault: default clock cycles per bus phase
//  - Reg*         : RTC register addresses
//  - next_state_of: successor of a timed state in the fixed bus-cycle sequence
package rtc_bus_ctrl_pkg;

  localparam int unsigned TPhaseDefault = 2;

  // RTC register map (time-keeping registers)
  localparam logic [7:0] RegSeconds = 8'h20;
  localparam logic [7:0] RegMinutes = 8'h21;
  localparam logic [7:0] RegHours   = 8'h22;

  typedef enum logic [3:0] {
    StIdle,
    StAdrSet,
    StAdrStb,
    StAdrHld,
    StGap,
    StDatSet,
    StDatStb,
    StDatHld,
    StDone
  } state_t;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad;
    logic en_ss;
    logic busy;
    logic done;
  } bus_ctl_t;

  localparam bus_ctl_t CtlIdle = '{
    cs_n:  1'b1,
    rd_n:  1'b1,
    wr_n:  1'b1,
    ad:    1'b0,
    en_ss: 1'b0,
    busy:  1'b0,
    done:  1'b0
  };

  function automatic state_t next_state_of(state_t s);
    state_t n;
    unique case (s)
      StAdrSet: n = StAdrStb;
      StAdrStb: n = StAdrHld;
      StAdrHld: n = StGap;
      StGap:    n = StDatSet;
      StDatSet: n = StDatStb;
      StDatStb: n = StDatHld;
      StDatHld: n = StDone;
      default:  n = StIdle;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Phase timer for the RTC bus sequencer.
// Counts 0 .. term while run is high and pulses phase_end on the last cycle of a phase,
// wrapping to 0 on that same edge. The sequencer advances exactly on phase_end, so the
// wrap doubles as the restart for the next state. Held at 0 while run is low.
// Ports:
//  clk       in  system clock
//  reset     in  asynchronous active-low reset
//  run       in  1 while the sequencer sits in a timed state
//  term      in  terminal count of the current phase (phase length - 1)
//  phase_end out 1 on the final cycle of the current phase
module rtc_bus_ctrl_phase_timer #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [CntW-1:0] term,
  output logic            phase_end
);

  localparam logic [CntW-1:0] One = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign phase_end = run && (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || phase_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Transaction sequencer for the multiplexed 8-bit address/data bus of the parallel RTC.
// One accepted start (read or write) is turned into address phase, bus turnaround and
// data phase. Feeds the external tri-state driver with en_ss/out_data and captures read
// data from the bus. All outputs are registered and reflect the current state.
// Optional feature (macro RTC_RD_SYNC_EN): rtc_bus_in is registered once before capture
// and the read strobe is stretched by one cycle so the registered value is captured.
// Ports:
//  clk        in   system clock, rising edge
//  reset      in   asynchronous active-low reset
//  start      in   request pulse, sampled only when idle
//  rw         in   1 = read, 0 = write (latched with start)
//  addr       in   RTC register address (latched with start)
//  wdata      in   write data (latched with start)
//  rtc_bus_in in   value currently on the RTC bus
//  out_data   out  data for the tri-state driver (address, then write data)
//  en_ss      out  tri-state driver enable
//  cs_n       out  chip select, active low
//  rd_n       out  read strobe, active low
//  wr_n       out  write strobe, active low (also latches the address)
//  ad         out  0 = address phase, 1 = data phase
//  busy       out  transaction in flight (ADR_SET .. DAT_HLD)
//  done       out  one-cycle completion pulse
//  rdata      out  last captured read data
module rtc_bus_ctrl
  import rtc_bus_ctrl_pkg::*;
#(
  parameter int unsigned T_PHASE = TPhaseDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] rtc_bus_in,
  output logic [7:0] out_data,
  output logic       en_ss,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  // Wide enough to hold T_PHASE itself (stretched read strobe).
  localparam int unsigned     CntW    = $clog2(T_PHASE + 2);
  localparam logic [CntW-1:0] TermStd = CntW'(T_PHASE - 1);

  state_t          state_q, state_d;
  logic            rw_q, rw_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  bus_ctl_t        ctl_q, ctl_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            run;
  logic            phase_end;
  logic            capture;
  logic [CntW-1:0] term;
  logic [7:0]      cap_src;

`ifdef RTC_RD_SYNC_EN
  localparam logic [CntW-1:0] TermExt = CntW'(T_PHASE);

  logic [7:0] bus_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_sync_q <= '0;
    end else begin
      bus_sync_q <= rtc_bus_in;
    end
  end

  // Read strobe gets one extra cycle so bus_sync_q holds a value sampled under rd_n = 0.
  assign term    = (state_q == StDatStb && rw_q) ? TermExt : TermStd;
  assign cap_src = bus_sync_q;
`else
  assign term    = TermStd;
  assign cap_src = rtc_bus_in;
`endif

  assign run = (state_q != StIdle) && (state_q != StDone);

  rtc_bus_ctrl_phase_timer #(
    .CntW(CntW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .term      (term),
    .phase_end (phase_end)
  );

  always_comb begin : next_state
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAdrSet;
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (phase_end) begin
          state_d = next_state_of(state_q);
        end
      end
    endcase
  end

  // Capture on the last cycle of the read strobe, while rd_n is still low.
  assign capture = (state_q == StDatStb) && rw_q && phase_end;
  assign rdata_d = capture ? cap_src : rdata_q;

  // Outputs are decoded from the next state so the registered outputs line up with it.
  always_comb begin : out_decode
    ctl_d      = CtlIdle;
    out_data_d = out_data_q;
    unique case (state_d)
      StAdrSet, StAdrStb, StAdrHld: begin
        ctl_d.cs_n  = 1'b0;
        ctl_d.en_ss = 1'b1;
        ctl_d.busy  = 1'b1;
        ctl_d.wr_n  = (state_d != StAdrStb);
        out_data_d  = addr_d;
      end
      StGap: begin
        // Turnaround: nobody drives, chip deselected.
        ctl_d.ad   = 1'b1;
        ctl_d.busy = 1'b1;
      end
      StDatSet, StDatStb, StDatHld: begin
        ctl_d.cs_n  = 1'b0;
        ctl_d.ad    = 1'b1;
        ctl_d.busy  = 1'b1;
        ctl_d.en_ss = !rw_d;
        if (state_d == StDatStb) begin
          ctl_d.wr_n = rw_d;
          ctl_d.rd_n = !rw_d;
        end
        if (!rw_d) begin
          out_data_d = wdata_d;
        end
      end
      StDone: begin
        ctl_d.ad   = 1'b1;
        ctl_d.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctl_q      <= CtlIdle;
      out_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctl_q      <= ctl_d;
      out_data_q <= out_data_d;
      rdata_q    <= rdata_d;
    end
  end

  assign out_data = out_data_q;
  assign en_ss    = ctl_q.en_ss;
  assign cs_n     = ctl_q.cs_n;
  assign rd_n     = ctl_q.rd_n;
  assign wr_n     = ctl_q.wr_n;
  assign ad       = ctl_q.ad;
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: one instance with T_PHASE = 2 (index 0), one with T_PHASE = 1
// (index 1). Each has its own RTC bus model returning rd_val while rd_n is low and the
// complement otherwise. Cycle c = 1 is the first cycle after the start-accept edge.
module tb_rtc_bus_ctrl;
  import rtc_bus_ctrl_pkg::*;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
    logic       en_ss;
    logic       busy;
    logic       done;
    logic [7:0] out_data;
    logic [7:0] rdata;
  } obs_t;

  typedef struct {
    int         d;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdv;
    int         restart_at;
    int         exp_done;
    int         exp_rdlow;
    int         exp_wrlow;
    logic [7:0] exp_rdata;
  } vec_t;

`ifdef RTC_RD_SYNC_EN
  localparam int SyncExt = 1;
`else
  localparam int SyncExt = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic       rw_v    [2];
  logic [7:0] addr_v  [2];
  logic [7:0] wdata_v [2];
  logic [7:0] rd_val  [2];
  logic [7:0] bus_in  [2];
  logic [7:0] od      [2];
  logic [7:0] rdat    [2];
  logic       en      [2];
  logic       cs      [2];
  logic       rd      [2];
  logic       wr      [2];
  logic       adv     [2];
  logic       bsy     [2];
  logic       dn      [2];
  obs_t       obs_a   [2];
  logic [7:0] exp_od  [2];
  logic [7:0] exp_rd  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus_in[i] = rd[i] ? ~rd_val[i] : rd_val[i];
      obs_a[i]  = {cs[i], rd[i], wr[i], adv[i], en[i], bsy[i], dn[i], od[i], rdat[i]};
    end
  end

  rtc_bus_ctrl #(.T_PHASE(2)) u_dut_p2 (
    .clk(clk), .reset(reset), .start(start_v[0]), .rw(rw_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .rtc_bus_in(bus_in[0]), .out_data(od[0]), .en_ss(en[0]),
    .cs_n(cs[0]), .rd_n(rd[0]), .wr_n(wr[0]), .ad(adv[0]), .busy(bsy[0]), .done(dn[0]),
    .rdata(rdat[0])
  );

  rtc_bus_ctrl #(.T_PHASE(1)) u_dut_p1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .rw(rw_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rtc_bus_in(bus_in[1]), .out_data(od[1]), .en_ss(en[1]),
    .cs_n(cs[1]), .rd_n(rd[1]), .wr_n(wr[1]), .ad(adv[1]), .busy(bsy[1]), .done(dn[1]),
    .rdata(rdat[1])
  );

  function automatic int period(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int ext(logic rw);
    return rw ? SyncExt : 0;
  endfunction

  function automatic obs_t reset_obs();
    obs_t e;
    e = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad: 1'b0, en_ss: 1'b0, busy: 1'b0,
          done: 1'b0, out_data: 8'h00, rdata: 8'h00};
    return e;
  endfunction

  // Expected outputs at cycle c of a transaction, from the phase timeline:
  // 5 phases of p cycles, a read strobe of p+s cycles, a hold of p cycles, 1 done cycle.
  function automatic obs_t expect_at(int p, int s, logic rw, logic [7:0] addr,
                                     logic [7:0] wdata, logic [7:0] rdv,
                                     logic [7:0] prev_od, logic [7:0] prev_rd, int c);
    obs_t e;
    int   seg;
    e          = reset_obs();
    e.out_data = prev_od;
    if (c <= 5 * p)                seg = (c - 1) / p;
    else if (c <= 6 * p + s)       seg = 5;
    else if (c <= 7 * p + s)       seg = 6;
    else if (c == 7 * p + s + 1)   seg = 7;
    else                           seg = 8;
    case (seg)
      0, 1, 2: begin
        e.cs_n = 1'b0; e.en_ss = 1'b1; e.busy = 1'b1; e.out_data = addr;
        e.wr_n = (seg != 1);
      end
      3: begin
        e.ad = 1'b1; e.busy = 1'b1; e.out_data = addr;
      end
      4, 5, 6: begin
        e.cs_n = 1'b0; e.ad = 1'b1; e.busy = 1'b1; e.en_ss = !rw;
        e.out_data = rw ? addr : wdata;
        if (seg == 5) begin
          e.rd_n = !rw;
          e.wr_n = rw;
        end
      end
      7: begin
        e.ad = 1'b1; e.done = 1'b1; e.out_data = rw ? addr : wdata;
      end
      default: e.out_data = rw ? addr : wdata;
    endcase
    e.rdata = (rw && c > 6 * p + s) ? rdv : prev_rd;
    return e;
  endfunction

  task automatic check_obs(input string name, input int c, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s c=%0d: got %h (cs,rd,wr,ad,en,busy,done,od,rdata) expected %h",
               name, c, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one transaction on instance d and compare every cycle through one idle cycle.
  // restart_at > 0 pulses start (with different request fields) during that cycle.
  task automatic run_txn(input int d, input logic rw, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdv,
                         input int restart_at, input string name,
                         output int done_cyc, output int rdlow, output int wrlow);
    int p;
    int s;
    int len;
    p        = period(d);
    s        = ext(rw);
    len      = 7 * p + s + 1;
    done_cyc = -1;
    rdlow    = 0;
    wrlow    = 0;
    rd_val[d]  = rdv;
    rw_v[d]    = rw;
    addr_v[d]  = addr;
    wdata_v[d] = wdata;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= len + 1; c++) begin
      start_v[d] = (c == restart_at);
      rw_v[d]    = ~rw;
      addr_v[d]  = addr ^ 8'h5A;
      wdata_v[d] = wdata ^ 8'hA5;
      check_obs(name, c, obs_a[d],
                expect_at(p, s, rw, addr, wdata, rdv, exp_od[d], exp_rd[d], c));
      if (obs_a[d].done && done_cyc < 0) done_cyc = c;
      if (!obs_a[d].rd_n) rdlow++;
      if (!obs_a[d].wr_n) wrlow++;
      @(posedge clk); #1;
    end
    start_v[d] = 1'b0;
    exp_od[d]  = rw ? addr : wdata;
    if (rw) exp_rd[d] = rdv;
  endtask

  vec_t       vecs [6];
  int         dc, rl, wl;
  int         rd_d;
  logic       r_rw;
  logic [7:0] r_addr, r_wdata, r_rdv;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; rw_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
      rd_val[i] = '0; exp_od[i] = '0; exp_rd[i] = '0;
    end

    // Directed vectors: {d, rw, addr, wdata, rdv, restart_at, done, rd low, wr low, rdata}
    vecs[0] = '{0, 1'b0, RegMinutes, 8'h59, 8'h00, 0, 15, 0, 4, 8'h00};
    vecs[1] = '{0, 1'b1, RegHours, 8'h00, 8'h37, 0, 15 + SyncExt, 2 + SyncExt, 2, 8'h37};
    vecs[2] = '{0, 1'b0, RegSeconds, 8'hC4, 8'h00, 5, 15, 0, 4, 8'h37};
    vecs[3] = '{1, 1'b1, 8'h00, 8'h00, 8'h11, 0, 8 + SyncExt, 1 + SyncExt, 1, 8'h11};
    vecs[4] = '{1, 1'b1, 8'h01, 8'h00, 8'h42, 0, 8 + SyncExt, 1 + SyncExt, 1, 8'h42};
    vecs[5] = '{1, 1'b0, 8'h05, 8'h99, 8'h00, 0, 8, 0, 2, 8'h42};

    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_p2", 0, obs_a[0], reset_obs());
    check_obs("reset_p1", 0, obs_a[1], reset_obs());
    #3 reset = 1'b1;
    @(posedge clk); #1;
    check_obs("idle_p2", 0, obs_a[0], reset_obs());

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].d, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdv,
              vecs[i].restart_at, $sformatf("vec%0d", i), dc, rl, wl);
      check_int($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      check_int($sformatf("vec%0d_rd_low", i), rl, vecs[i].exp_rdlow);
      check_int($sformatf("vec%0d_wr_low", i), wl, vecs[i].exp_wrlow);
      check_int($sformatf("vec%0d_rdata", i), int'(rdat[vecs[i].d]), int'(vecs[i].exp_rdata));
    end

    // Reset during ADR_STB of a write on the T_PHASE = 2 instance.
    rw_v[0] = 1'b0; addr_v[0] = 8'h33; wdata_v[0] = 8'h44; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_obs("rst_pre", 3, obs_a[0],
              expect_at(2, 0, 1'b0, 8'h33, 8'h44, 8'h00, exp_od[0], exp_rd[0], 3));
    #2 reset = 1'b0;
    #1;
    check_obs("rst_now_p2", 0, obs_a[0], reset_obs());
    check_obs("rst_now_p1", 0, obs_a[1], reset_obs());
    for (int i = 0; i < 2; i++) begin
      exp_od[i] = '0;
      exp_rd[i] = '0;
    end
    repeat (3) begin
      @(posedge clk); #1;
      check_obs("rst_hold", 0, obs_a[0], reset_obs());
    end
    #3 reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_obs("rst_after", 0, obs_a[0], reset_obs());
    end
    run_txn(0, 1'b1, RegHours, 8'h00, 8'h6E, 0, "post_rst", dc, rl, wl);
    check_int("post_rst_done_cycle", dc, 15 + SyncExt);

    // Random traffic on both instances.
    for (int k = 0; k < 24; k++) begin
      rd_d    = int'($urandom_range(1, 0));
      r_rw    = 1'($urandom_range(1, 0));
      r_addr  = 8'($urandom);
      r_wdata = 8'($urandom);
      r_rdv   = 8'($urandom);
      run_txn(rd_d, r_rw, r_addr, r_wdata, r_rdv, 0, "rand", dc, rl, wl);
      check_int("rand_done_cycle", dc, 7 * period(rd_d) + ext(r_rw) + 1);
      check_int("rand_rd_low", rl, r_rw ? period(rd_d) + ext(r_rw) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
